wb_commit_trace: RTL and testbench

- Hardware trace buffer on the write-back side of the 5-stage pipelined register-file datapath.
- Captures every architectural register write at WB (address, data, cycle stamp) into a FIFO.
- A host or bench drains the FIFO through a valid/ready read port, so commits can be checked without probing internal pipeline wires.

---
 rtl/wb_commit_trace.sv | 153 +++++++++++++++
 tb/tb_wb_commit_trace.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_trace.sv
// rtl/wb_commit_trace.sv - write-back commit trace FIFO with cycle stamps, FWFT read port and drop accounting.
// Optional build macro: WB_TRACE_DEDUP_EN suppresses a commit identical to the last captured one.
`timescale 1ns/1ps
module wb_commit_trace #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen_WB,
  input  logic [4:0]               waddr_MEM_WB,
  input  logic [31:0]              wdata_WB,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [4:0]               rd_waddr,
  output logic [31:0]              rd_wdata,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               dropped_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]         waddr;
    logic [31:0]        wdata;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         dropped_q, dropped_d;

  logic   full, empty, qualify, push_req, pop, push_ok, drop;
  entry_t head;

`ifdef WB_TRACE_DEDUP_EN
  logic        last_valid_q, last_valid_d;
  logic [4:0]  last_waddr_q, last_waddr_d;
  logic [31:0] last_wdata_q, last_wdata_d;
  logic        dup;
`endif

  always_comb begin
    full    = (count_q == CW'(DEPTH));
    empty   = (count_q == '0);
    qualify = wen_WB && (waddr_MEM_WB != 5'd0);
`ifdef WB_TRACE_DEDUP_EN
    // Compared against the last stored entry even if it has already been drained.
    dup      = last_valid_q && (last_waddr_q == waddr_MEM_WB) && (last_wdata_q == wdata_WB);
    push_req = qualify && !dup;
`else
    push_req = qualify;
`endif
    pop     = !empty && rd_ready;
    // A full FIFO still accepts a commit when the head leaves in the same cycle.
    push_ok = push_req && (!full || pop);
    drop    = push_req && full && !pop;
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    stamp_d    = stamp_q + STAMP_W'(1);
    overflow_d = overflow_q | drop;
    dropped_d  = dropped_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = '{waddr: waddr_MEM_WB, wdata: wdata_WB, stamp: stamp_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

`ifdef WB_TRACE_DEDUP_EN
  always_comb begin
    last_valid_d = last_valid_q;
    last_waddr_d = last_waddr_q;
    last_wdata_d = last_wdata_q;
    if (push_ok) begin
      last_valid_d = 1'b1;
      last_waddr_d = waddr_MEM_WB;
      last_wdata_d = wdata_WB;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid_q <= 1'b0;
      last_waddr_q <= '0;
      last_wdata_q <= '0;
    end else begin
      last_valid_q <= last_valid_d;
      last_waddr_q <= last_waddr_d;
      last_wdata_q <= last_wdata_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      stamp_q    <= stamp_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

  // First-word-fall-through head, forced to zero while empty.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    rd_valid = !empty;
    rd_waddr = empty ? '0 : head.waddr;
    rd_wdata = empty ? '0 : head.wdata;
    rd_stamp = empty ? '0 : head.stamp;
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_wb_commit_trace.sv
// tb/tb_wb_commit_trace.sv - directed self-checking bench for wb_commit_trace (DEPTH=16, STAMP_W=16).
`timescale 1ns/1ps
module tb_wb_commit_trace;

  logic        clk;
  logic        rst;
  logic        wen_WB;
  logic [4:0]  waddr_MEM_WB;
  logic [31:0] wdata_WB;
  logic        rd_ready;
  logic        rd_valid;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic [15:0] rd_stamp;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  dropped_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] tb_stamp;
  logic [4:0]  exp_a [18];
  logic [31:0] exp_d [18];
  logic [15:0] exp_s [18];
  logic [15:0] new_s;

  wb_commit_trace #(.DEPTH(16), .STAMP_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .wen_WB       (wen_WB),
    .waddr_MEM_WB (waddr_MEM_WB),
    .wdata_WB     (wdata_WB),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_waddr     (rd_waddr),
    .rd_wdata     (rd_wdata),
    .rd_stamp     (rd_stamp),
    .count        (count),
    .overflow     (overflow),
    .dropped_cnt  (dropped_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle stamp: zero under reset, +1 per rising edge otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_stamp <= '0;
    else     tb_stamp <= tb_stamp + 16'd1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wen_WB       = 1'b1;
    waddr_MEM_WB = a;
    wdata_WB     = d;
    @(negedge clk);
    wen_WB       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wen_WB = 1'b0; waddr_MEM_WB = '0; wdata_WB = '0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_dropped", dropped_cnt, 0);
    check("rst_rd_waddr", rd_waddr, 0);
    check("rst_rd_wdata", rd_wdata, 0);
    check("rst_rd_stamp", rd_stamp, 0);

    // Release, let three edges pass, then capture at stamp 3.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push(5'd5, 32'h0000_000A);
    check("p1_valid", rd_valid, 1);
    check("p1_waddr", rd_waddr, 5);
    check("p1_wdata", rd_wdata, 32'hA);
    check("p1_stamp", rd_stamp, 3);
    check("p1_count", count, 1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check("pop1_valid", rd_valid, 0);
    check("pop1_count", count, 0);
    check("pop1_wdata", rd_wdata, 0);

    push(5'd0, 32'hDEAD_BEEF);
    check("r0_count", count, 0);
    check("r0_valid", rd_valid, 0);

    rd_ready = 1'b1;
    @(negedge clk);
    check("empty_ready_count", count, 0);
    push(5'd7, 32'h0000_0077);
    check("empty_push_ready_count", count, 1);
    check("empty_push_ready_valid", rd_valid, 1);
    @(negedge clk);
    rd_ready = 1'b0;
    check("drain7_count", count, 0);

    // 18 pushes into a 16-deep FIFO: last two dropped.
    for (int i = 0; i < 18; i++) begin
      exp_a[i] = 5'(i + 1);
      exp_d[i] = 32'h1000 + i;
      exp_s[i] = tb_stamp;
      push(exp_a[i], exp_d[i]);
    end
    check("burst_count", count, 16);
    check("burst_overflow", overflow, 1);
    check("burst_dropped", dropped_cnt, 2);
    check("head0_waddr", rd_waddr, exp_a[0]);
    check("head0_wdata", rd_wdata, exp_d[0]);
    check("head0_stamp", rd_stamp, exp_s[0]);

    // Full with simultaneous push and pop.
    new_s = tb_stamp;
    rd_ready = 1'b1;
    push(5'd9, 32'h0000_BEEF);
    check("fullpp_count", count, 16);
    check("fullpp_dropped", dropped_cnt, 2);
    for (int k = 1; k < 16; k++) begin
      check($sformatf("drain%0d_waddr", k), rd_waddr, exp_a[k]);
      check($sformatf("drain%0d_wdata", k), rd_wdata, exp_d[k]);
      check($sformatf("drain%0d_stamp", k), rd_stamp, exp_s[k]);
      @(negedge clk);
    end
    check("last_waddr", rd_waddr, 9);
    check("last_wdata", rd_wdata, 32'hBEEF);
    check("last_stamp", rd_stamp, new_s);
    @(negedge clk);
    rd_ready = 1'b0;
    check("drained_count", count, 0);
    check("drained_valid", rd_valid, 0);
    check("sticky_overflow", overflow, 1);

    // Saturate the drop counter: 2 + 260 drops clamps at 255.
    for (int i = 0; i < 276; i++) push(5'd12, 32'h2000 + i);
    check("sat_count", count, 16);
    check("sat_dropped", dropped_cnt, 255);

    rd_ready = 1'b1;
    repeat (9) @(negedge clk);
    rd_ready = 1'b0;
    check("mid_count", count, 7);

    // Async reset pulse of 1 ns between edges, during an active write burst.
    wen_WB = 1'b1; waddr_MEM_WB = 5'd4; wdata_WB = 32'h44;
    #1;
    rst = 1'b1;
    #0.5;
    check("async_count", count, 0);
    check("async_valid", rd_valid, 0);
    check("async_overflow", overflow, 0);
    check("async_dropped", dropped_cnt, 0);
    #0.5;
    rst = 1'b0;
    wen_WB = 1'b0;
    @(negedge clk);
    check("post_rst_count", count, 0);

    push(5'd3, 32'h55);
    push(5'd3, 32'h55);
    push(5'd3, 32'h56);
`ifdef WB_TRACE_DEDUP_EN
    check("dedup_count", count, 2);
    rd_ready = 1'b1;
    check("dedup_e0", rd_wdata, 32'h55);
    @(negedge clk);
    check("dedup_e1", rd_wdata, 32'h56);
`else
    check("nodedup_count", count, 3);
    rd_ready = 1'b1;
    check("nodedup_e0", rd_wdata, 32'h55);
    @(negedge clk);
    check("nodedup_e1", rd_wdata, 32'h55);
    @(negedge clk);
    check("nodedup_e2", rd_wdata, 32'h56);
`endif
    @(negedge clk);
    rd_ready = 1'b0;
    check("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
